// File: rtl/stage_sequencer.sv
// Multi-cycle Y86 instruction sequencer: steps one instruction at a time through the
// fetch/decode/execute/memory/writeback/PC-update stages and drives the datapath enables.
module stage_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             cnd_i,
  input  logic             dmem_ready_i,
  input  logic             dmem_error_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             exec_en_o,
  output logic             mem_en_o,
  output logic             wb_en_o,
  output logic             dmem_req_o,
  output logic             regwe_e_o,
  output logic             regwe_m_o,
  output logic             cc_we_o,
  output logic             pc_we_o,
  output logic [2:0]       stat_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, nextState;
  logic [2:0]        faultCode;
  logic [3:0]        icodeQ;
  logic              cndQ;
  logic [WAIT_W-1:0] waitCnt;
  logic [2:0]        statQ;
  logic [CNT_W-1:0]  retiredQ;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  function automatic logic isMemOp(input logic [3:0] icode);
    return icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic writesValE(input logic [3:0] icode, input logic cnd);
    return (icode inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (icode == 4'h2 && cnd);
  endfunction

  function automatic logic writesValM(input logic [3:0] icode);
    return icode inside {4'h5, 4'hB};
  endfunction

  always_comb begin
    nextState = state;
    faultCode = STAT_AOK;
    case (state)
      IDLE:      if (start_i) nextState = FETCH;
      // The latch is being loaded this cycle, so the halt check looks at the live icode.
      FETCH: begin
        if (imem_error_i) begin
          nextState = HALTED;
          faultCode = STAT_ADR;
        end else if (!instr_valid_i) begin
          nextState = HALTED;
          faultCode = STAT_INS;
        end else if (icode_i == 4'h0) begin
          nextState = HALTED;
          faultCode = STAT_HLT;
        end else begin
          nextState = DECODE;
        end
      end
      DECODE:    nextState = EXECUTE;
      EXECUTE:   nextState = isMemOp(icodeQ) ? MEMORY : WRITEBACK;
      MEMORY: begin
        if (dmem_ready_i) begin
          nextState = dmem_error_i ? HALTED : WRITEBACK;
          faultCode = dmem_error_i ? STAT_ADR : STAT_AOK;
        end else if (waitCnt == WAIT_LAST) begin
          nextState = HALTED;
          faultCode = STAT_ADR;
        end
      end
      WRITEBACK: nextState = PCUPD;
      PCUPD:     nextState = FETCH;
      HALTED:    nextState = HALTED;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      icodeQ   <= 4'h0;
      cndQ     <= 1'b0;
      waitCnt  <= '0;
      statQ    <= STAT_AOK;
      retiredQ <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH)   icodeQ <= icode_i;
      if (state == EXECUTE) cndQ   <= cnd_i;
      // Counter is held at zero outside MEMORY so every entry starts a fresh wait.
      waitCnt <= (state == MEMORY) ? waitCnt + 1'b1 : '0;
      if (nextState == HALTED && state != HALTED) statQ <= faultCode;
      if (state == PCUPD) retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  assign fetch_en_o  = (state == FETCH);
  assign decode_en_o = (state == DECODE);
  assign exec_en_o   = (state == EXECUTE);
  assign mem_en_o    = (state == MEMORY);
  assign wb_en_o     = (state == WRITEBACK);
  assign dmem_req_o  = (state == MEMORY);
  assign cc_we_o     = (state == EXECUTE) && (icodeQ == 4'h6);
  assign regwe_e_o   = (state == WRITEBACK) && writesValE(icodeQ, cndQ);
  assign regwe_m_o   = (state == WRITEBACK) && writesValM(icodeQ);
  assign pc_we_o     = (state == PCUPD);
  assign stat_o      = statQ;
  assign busy_o      = (state != IDLE) && (state != HALTED);
  assign retired_o   = retiredQ;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a table of single-instruction runs plus
// hand-written sequences for stage ordering, reset mid-MEMORY and HALTED behaviour.
module tb_stage_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [3:0]  icode_i;
  logic        instr_valid_i;
  logic        imem_error_i;
  logic        cnd_i;
  logic        dmem_ready_i;
  logic        dmem_error_i;
  logic        fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o;
  logic        dmem_req_o, regwe_e_o, regwe_m_o, cc_we_o, pc_we_o;
  logic [2:0]  stat_o;
  logic        busy_o;
  logic [31:0] retired_o;

  int checks = 0;
  int errors = 0;

  stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .icode_i(icode_i),
    .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i), .cnd_i(cnd_i),
    .dmem_ready_i(dmem_ready_i), .dmem_error_i(dmem_error_i),
    .fetch_en_o(fetch_en_o), .decode_en_o(decode_en_o), .exec_en_o(exec_en_o),
    .mem_en_o(mem_en_o), .wb_en_o(wb_en_o), .dmem_req_o(dmem_req_o),
    .regwe_e_o(regwe_e_o), .regwe_m_o(regwe_m_o), .cc_we_o(cc_we_o),
    .pc_we_o(pc_we_o), .stat_o(stat_o), .busy_o(busy_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] icode;
    logic       valid;
    logic       imemErr;
    logic       cnd;
    int         readyAt;   // MEMORY cycle on which ready is given, 0 = never
    logic       dmemErr;
    logic [2:0] expStat;
    int         expRet;
    int         expMem;
    logic       expRegE;
    logic       expRegM;
    logic       expCc;
    int         expPc;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n_i = 1'b0;
    start_i = 1'b0;
    dmem_ready_i = 1'b0;
    dmem_error_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic runVec(input int idx, input vec_t v);
    int mem, pc, k;
    logic regE, regM, cc, done;
    mem = 0; pc = 0; k = 0;
    regE = 1'b0; regM = 1'b0; cc = 1'b0; done = 1'b0;
    doReset();
    icode_i = v.icode;
    instr_valid_i = v.valid;
    imem_error_i = v.imemErr;
    cnd_i = !v.cnd;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk_i);
      #1;
      k++;
      icode_i = v.icode ^ 4'hF;
      cnd_i = exec_en_o ? v.cnd : !v.cnd;
      dmem_ready_i = (v.readyAt != 0) && dmem_req_o && ((mem + 1) == v.readyAt);
      dmem_error_i = dmem_ready_i && v.dmemErr;
      #1;
      if (fetch_en_o || !busy_o) begin
        done = 1'b1;
      end else begin
        mem += int'(dmem_req_o);
        pc += int'(pc_we_o);
        regE |= regwe_e_o;
        regM |= regwe_m_o;
        cc |= cc_we_o;
      end
    end
    dmem_ready_i = 1'b0;
    dmem_error_i = 1'b0;
    chk($sformatf("v%0d_finished", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_stat", idx), 32'(stat_o), 32'(v.expStat));
    chk($sformatf("v%0d_busy", idx), 32'(busy_o), 32'(v.expStat == 3'd1));
    chk($sformatf("v%0d_retired", idx), retired_o, 32'(v.expRet));
    chk($sformatf("v%0d_memcycles", idx), 32'(mem), 32'(v.expMem));
    chk($sformatf("v%0d_regwe_e", idx), 32'(regE), 32'(v.expRegE));
    chk($sformatf("v%0d_regwe_m", idx), 32'(regM), 32'(v.expRegM));
    chk($sformatf("v%0d_cc_we", idx), 32'(cc), 32'(v.expCc));
    chk($sformatf("v%0d_pc_we", idx), 32'(pc), 32'(v.expPc));
  endtask

  initial begin
    logic [6:0] seqExp[5];
    //         icode valid imem cnd rdy derr stat ret mem  rE   rM   cc   pc
    vecs[0]  = '{4'h3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd1, 1, 0,  1'b1, 1'b0, 1'b0, 1}; // irmovq
    vecs[1]  = '{4'h5, 1'b1, 1'b0, 1'b0, 3, 1'b0, 3'd1, 1, 3,  1'b0, 1'b1, 1'b0, 1}; // mrmovq wait 3
    vecs[2]  = '{4'h2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd1, 1, 0,  1'b0, 1'b0, 1'b0, 1}; // cmov not taken
    vecs[3]  = '{4'h2, 1'b1, 1'b0, 1'b1, 0, 1'b0, 3'd1, 1, 0,  1'b1, 1'b0, 1'b0, 1}; // cmov taken
    vecs[4]  = '{4'h6, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd1, 1, 0,  1'b1, 1'b0, 1'b1, 1}; // OPq
    vecs[5]  = '{4'h4, 1'b1, 1'b0, 1'b0, 1, 1'b0, 3'd1, 1, 1,  1'b0, 1'b0, 1'b0, 1}; // rmmovq
    vecs[6]  = '{4'hB, 1'b1, 1'b0, 1'b0, 2, 1'b0, 3'd1, 1, 2,  1'b1, 1'b1, 1'b0, 1}; // popq
    vecs[7]  = '{4'h3, 1'b0, 1'b1, 1'b0, 0, 1'b0, 3'd3, 0, 0,  1'b0, 1'b0, 1'b0, 0}; // imem err + invalid
    vecs[8]  = '{4'h3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'd4, 0, 0,  1'b0, 1'b0, 1'b0, 0}; // invalid
    vecs[9]  = '{4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd2, 0, 0,  1'b0, 1'b0, 1'b0, 0}; // halt
    vecs[10] = '{4'hA, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd3, 0, 15, 1'b0, 1'b0, 1'b0, 0}; // timeout
    vecs[11] = '{4'h8, 1'b1, 1'b0, 1'b0, 2, 1'b1, 3'd3, 0, 2,  1'b0, 1'b0, 1'b0, 0}; // dmem error
    vecs[12] = '{4'h7, 1'b1, 1'b0, 1'b1, 0, 1'b0, 3'd1, 1, 0,  1'b0, 1'b0, 1'b0, 1}; // jXX
    vecs[13] = '{4'h0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 3'd3, 0, 0,  1'b0, 1'b0, 1'b0, 0}; // imem err beats halt
    vecs[14] = '{4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 3'd4, 0, 0,  1'b0, 1'b0, 1'b0, 0}; // invalid beats halt

    icode_i = 4'h0; instr_valid_i = 1'b0; imem_error_i = 1'b0; cnd_i = 1'b0;
    start_i = 1'b0; dmem_ready_i = 1'b0; dmem_error_i = 1'b0; rst_n_i = 1'b0;

    for (int i = 0; i < 15; i++) runVec(i, vecs[i]);

    // Stage ordering for irmovq, checked cycle by cycle from reset
    doReset();
    chk("idle_outputs", {fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o,
                         dmem_req_o, regwe_e_o, regwe_m_o, cc_we_o, pc_we_o}, 32'd0);
    chk("idle_stat", 32'(stat_o), 32'd1);
    chk("idle_retired", retired_o, 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 chk("idle_waits_start", 32'({fetch_en_o, busy_o}), 32'd0);
    icode_i = 4'h3; instr_valid_i = 1'b1; imem_error_i = 1'b0; start_i = 1'b1;
    // {fetch, decode, exec, mem, wb, pc_we, regwe_e}
    seqExp[0] = 7'b1000000;
    seqExp[1] = 7'b0100000;
    seqExp[2] = 7'b0010000;
    seqExp[3] = 7'b0000101;
    seqExp[4] = 7'b0000010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1 start_i = 1'b0;
      chk($sformatf("irmov_step%0d", i),
          32'({fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o, pc_we_o, regwe_e_o}),
          32'(seqExp[i]));
      chk($sformatf("irmov_busy%0d", i), 32'(busy_o), 32'd1);
    end
    @(posedge clk_i);
    #1 chk("irmov_refetch", 32'(fetch_en_o), 32'd1);
    chk("irmov_retired", retired_o, 32'd1);

    // Reset while mrmovq waits in MEMORY
    icode_i = 4'h5;
    repeat (4) @(posedge clk_i);
    #1 chk("mrmov_in_memory", 32'({mem_en_o, dmem_req_o}), 32'd3);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_outputs", {fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o,
                        dmem_req_o, regwe_e_o, regwe_m_o, cc_we_o, pc_we_o}, 32'd0);
    chk("rst_stat", 32'(stat_o), 32'd1);
    chk("rst_retired", retired_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 chk("rst_idle_hold", 32'({fetch_en_o, busy_o, pc_we_o}), 32'd0);
    chk("rst_idle_retired", retired_o, 32'd0);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    chk("rst_restart_fetch", 32'(fetch_en_o), 32'd1);

    // HALTED ignores start_i
    doReset();
    icode_i = 4'h0; instr_valid_i = 1'b1; imem_error_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(posedge clk_i);
    #1 start_i = 1'b1;
    icode_i = 4'h3;
    repeat (3) @(posedge clk_i);
    #1;
    chk("halted_ignores_start", 32'({fetch_en_o, busy_o}), 32'd0);
    chk("halted_stat_held", 32'(stat_o), 32'd2);
    chk("halted_retired", retired_o, 32'd0);
    start_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
